// File: rtl/column_window.sv
// Presents a 7-pixel vertical column (rows y-6..y at the current x) from six line buffers.
// Latency 1 cycle; one pixel per clock, no backpressure (in_valid only qualifies the input).
module column_window #(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_pix,
    input  logic             in_sof,
    output logic [7:0]       out0,
    output logic [7:0]       out1,
    output logic [7:0]       out2,
    output logic [7:0]       out3,
    output logic [7:0]       out4,
    output logic [7:0]       out5,
    output logic [7:0]       out6,
    output logic             out_valid,
    output logic [COL_W-1:0] out_col
);

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] eff_col;
    logic [2:0]       rows;
    logic [2:0]       eff_rows;
    logic             last_col;

    logic [7:0] lb [0:5][0:IMG_WIDTH-1];
    logic [7:0] rd [0:5];

    // A start-of-frame pixel is always column 0 of row 0, whatever the counters say.
    always_comb begin
        eff_col  = in_sof ? '0 : col;
        eff_rows = in_sof ? 3'd0 : rows;
        last_col = (eff_col == COL_W'(IMG_WIDTH - 1));
        for (int k = 0; k < 6; k++) begin
            rd[k] = lb[k][eff_col];
        end
    end

    // Buffers are read at eff_col in the same cycle they are written, so each
    // column shifts down one line per accepted pixel without extra latency.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb[0][eff_col] <= in_pix;
            for (int k = 1; k < 6; k++) begin
                lb[k][eff_col] <= rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
            out5      <= '0;
            out6      <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            col       <= '0;
            rows      <= '0;
        end else if (in_valid) begin
            out6      <= in_pix;
            out5      <= rd[0];
            out4      <= rd[1];
            out3      <= rd[2];
            out2      <= rd[3];
            out1      <= rd[4];
            out0      <= rd[5];
            out_col   <= eff_col;
            out_valid <= (eff_rows == 3'd6);
            if (last_col) begin
                col  <= '0;
                rows <= (eff_rows == 3'd6) ? 3'd6 : eff_rows + 3'd1;
            end else begin
                col  <= eff_col + 1'b1;
                rows <= eff_rows;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_column_window.sv
// Randomized bench for column_window against a frame-history reference model.
module tb_column_window;

    localparam int W    = 8;
    localparam int CW   = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_pix;
    logic          in_sof;
    logic [7:0]    out0, out1, out2, out3, out4, out5, out6;
    logic          out_valid;
    logic [CW-1:0] out_col;

    column_window #(.IMG_WIDTH(W), .COL_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix), .in_sof(in_sof),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
        .out6(out6), .out_valid(out_valid), .out_col(out_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] obs [7];
    assign obs[0] = out0;
    assign obs[1] = out1;
    assign obs[2] = out2;
    assign obs[3] = out3;
    assign obs[4] = out4;
    assign obs[5] = out5;
    assign obs[6] = out6;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every pixel of the current frame is recorded by its
    // (row, col) position; a valid column at row r is rows r-6..r at that x.
    logic [7:0] hist [16][W];
    int         mr, mc;
    logic [7:0] e_out [7];
    int         e_col;
    bit         e_vld;
    bit         e_known;

    task automatic model_reset();
        mr = 0;
        mc = 0;
        for (int k = 0; k < 7; k++) e_out[k] = 8'h00;
        e_col   = 0;
        e_vld   = 1'b0;
        e_known = 1'b1;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".vld"}, int'(out_valid), int'(e_vld));
        check({ph, ".col"}, int'(out_col), e_col);
        check({ph, ".out6"}, int'(out6), int'(e_out[6]));
        if (e_known) begin
            for (int k = 0; k < 6; k++)
                check($sformatf("%s.out%0d", ph, k), int'(obs[k]), int'(e_out[k]));
        end
    endtask

    task automatic step(input string ph, input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_pix   = p;
        @(posedge clk);
        #1;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            hist[mr & 15][mc] = p;
            e_vld    = (mr >= 6);
            e_known  = e_vld;
            e_out[6] = p;
            e_col    = mc;
            if (e_vld) begin
                for (int k = 0; k < 6; k++) e_out[k] = hist[(mr - 6 + k) & 15][mc];
            end
            if (mc == W - 1) begin
                mc = 0;
                mr++;
            end else begin
                mc++;
            end
        end else begin
            e_vld = 1'b0;
        end
        check_outputs(ph);
    endtask

    task automatic maybe_bubble(input string ph);
        if ($urandom_range(3) == 0)
            step(ph, 1'b0, 1'($urandom), 8'($urandom));
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = 8'h00;
        model_reset();

        // Held in reset with activity on the inputs: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_sof   = 1'($urandom);
            in_pix   = 8'($urandom);
            @(posedge clk);
            #1;
            check("rst", {out0, out1, out2, out3, out4, out5, out6} == 56'd0 ? 1 : 0, 1);
            check("rst.vld", int'(out_valid), 0);
            check("rst.col", int'(out_col), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;

        // Frame A: fill, first windows, wraps, bubbles; restart with sof at row 8 col 4.
        begin : frame_a
            for (int r = 0; r < 9; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r == 8 && c == 4) disable frame_a;
                    if (r >= 6) maybe_bubble("a.gap");
                    step("a", 1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                end
            end
        end

        // Frame B: random pixels, starts mid-line; async reset drops at row 7 col 3.
        begin : frame_b
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r >= 5) maybe_bubble("b.gap");
                    step("b", 1'b1, (r == 0 && c == 0), 8'($urandom));
                    if (r == 7 && c == 3) disable frame_b;
                end
            end
        end
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        check_outputs("arst.hold");
        rst = 1'b1;

        // Frame C: same pattern as frame A must reproduce the fill values.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r >= 6) maybe_bubble("c.gap");
                step("c", 1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
            end
        end
        step("c.tail", 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/column_window.md
# column_window

Upstream stage of the 7x7 median filter datapath. Takes a raster-order 8-bit pixel stream and holds the six previous image lines in on-chip line buffers. For every accepted pixel it presents a 7-pixel vertical column: the pixel at the same x from the current row and the six rows above. That column drives `in0..in6` of `sort_column` directly.

## Interface

Parameters:
- `IMG_WIDTH`, 640: pixels per line; legal range 8..1023.
- `COL_W`, 10: width of the column counter; must satisfy 2^COL_W >= IMG_WIDTH.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `in_valid`  in  1  `in_pix` carries a pixel this cycle.
- `in_pix`  in  8  pixel value.
- `in_sof`  in  1  start of frame; only sampled when `in_valid`=1.
- `out0`  out  8  pixel from row y-6, oldest (top of window).
- `out1`..`out5`  out  8 each  pixels from rows y-5..y-1.
- `out6`  out  8  pixel from row y, the current input pixel.
- `out_valid`  out  1  `out0..out6` hold a complete column.
- `out_col`  out  COL_W  x coordinate of the presented column.

## Operation

State:
- `col` counter, COL_W bits.
- `rows` counter, 3 bits, saturating at 6.
- Six line buffers `lb0..lb5`, each IMG_WIDTH x 8, all sharing address `col`.
- Buffer contents are not reset.

Per cycle with `in_valid`=1:
- If `in_sof`=1, the pixel is treated as col=0, row=0: the effective `col` and `rows` are 0 for this pixel.
- Line buffers are read before they are written, at the effective `col`.
- Output registers load: `out6`<=`in_pix`, `out5`<=`lb0[col]`, `out4`<=`lb1[col]`, `out3`<=`lb2[col]`, `out2`<=`lb3[col]`, `out1`<=`lb4[col]`, `out0`<=`lb5[col]`. `out_col`<=effective `col`.
- Line buffers shift one row: `lb0[col]`<=`in_pix`, then `lbk[col]`<=old `lb(k-1)[col]` for k=1..5.
- `out_valid`<=1 if effective `rows`==6, else 0.
- Counter update:
  - If effective `col`==IMG_WIDTH-1: `col`<=0 and `rows`<=min(effective `rows`+1, 6).
  - Otherwise: `col`<=effective `col`+1 and `rows` is unchanged.

Per cycle with `in_valid`=0:
- `out_valid`<=0.
- `out0..out6`, `out_col`, `col` and `rows` hold their values.
- Buffers are not written.
- `in_sof` is ignored.

Boundaries:
- Column wrap is at IMG_WIDTH-1, not at 2^COL_W-1.
- No horizontal or vertical border padding. Rows 0..5 of each frame produce no valid output; row 6 onward does.
- `in_sof` mid-frame abandons the current frame. `rows` restarts at 0, so output stays invalid for six full lines. Stale buffer data is never marked valid.
- `in_sof` arriving with col already 0 and rows 0 behaves identically to a normal first pixel.

## Timing

- Reset (`rst`=0, asynchronous): `out0..out6`=0, `out_col`=0, `out_valid`=0, `col`=0, `rows`=0. All take effect immediately, without waiting for a clock edge.
- Reset release is synchronous to `clk` from the block's point of view. The first edge with `rst`=1 may accept a pixel.
- Latency is 1 cycle: the pixel accepted at edge N appears on `out6` with `out_valid`, valid from edge N until edge N+1.
- Throughput is one pixel per clock and there is no backpressure. Downstream must accept every cycle with `out_valid`=1.
- Line buffers are inferred as synchronous-read block RAM or as distributed RAM. The read-before-write behaviour must hold with no additional latency.
- Reset asserted mid-frame clears the counters and outputs. The next frame must begin with `in_sof`, or is treated as starting at row 0 regardless.

## Test plan

Benches use IMG_WIDTH=8 and pixel value = row*16+col.

- Reset check: hold `rst`=0 with `in_valid` toggling -> all outputs stay 0 and `out_valid`=0. Release reset -> first accepted pixel sets `out6`=0x00 one cycle later.
- Fill and first window: stream 7 full rows with `in_sof` on the first pixel -> `out_valid`=0 for the first 48 pixels. On row 6 col 0: `out0..out6`=0x00,0x10,0x20,0x30,0x40,0x50,0x60 and `out_col`=0. At row 6 col 3: 0x03..0x63 and `out_col`=3.
- Wrap: after row 6 col 7 (`out6`=0x67, `out_col`=7) the next pixel gives `out_col`=0 and `out0`=0x10, `out6`=0x70. `out_valid` stays 1.
- Gaps: insert random `in_valid`=0 bubbles in rows 6-7 -> outputs hold during each bubble with `out_valid`=0. The column sequence is identical to the gapless run.
- Mid-frame restart: assert `in_sof` at row 8 col 4 -> `out_valid`=0 for the next 48 accepted pixels, then the correct column from the new frame appears.
- Async reset mid-stream: drop `rst` between edges at row 7 -> outputs clear to 0 within the same cycle. After release, a new frame with `in_sof` reproduces the fill-scenario values.
